// File: rtl/pht_if.sv
// Lookup, prediction and training signals between the fetch/resolve logic and the PHT.
interface pht_if #(
  parameter int unsigned BHR_WIDTH      = 3,
  parameter int unsigned PC_INDEX_WIDTH = 3
);
  // Lookup requests, one per fetch slot
  logic                      rd_valid0;
  logic [PC_INDEX_WIDTH-1:0] rd_pc_idx0;
  logic [BHR_WIDTH-1:0]      rd_hist0;
  logic                      rd_valid1;
  logic [PC_INDEX_WIDTH-1:0] rd_pc_idx1;
  logic [BHR_WIDTH-1:0]      rd_hist1;

  // Registered predictions
  logic                      pred_valid0;
  logic                      pred_taken0;
  logic [1:0]                pred_cnt0;
  logic                      pred_valid1;
  logic                      pred_taken1;
  logic [1:0]                pred_cnt1;

  // Training at branch resolution
  logic                      upd_en;
  logic [PC_INDEX_WIDTH-1:0] upd_pc_idx;
  logic [BHR_WIDTH-1:0]      upd_hist;
  logic                      upd_taken;

  modport master (
    output rd_valid0, rd_pc_idx0, rd_hist0,
    output rd_valid1, rd_pc_idx1, rd_hist1,
    output upd_en, upd_pc_idx, upd_hist, upd_taken,
    input  pred_valid0, pred_taken0, pred_cnt0,
    input  pred_valid1, pred_taken1, pred_cnt1
  );

  modport slave (
    input  rd_valid0, rd_pc_idx0, rd_hist0,
    input  rd_valid1, rd_pc_idx1, rd_hist1,
    input  upd_en, upd_pc_idx, upd_hist, upd_taken,
    output pred_valid0, pred_taken0, pred_cnt0,
    output pred_valid1, pred_taken1, pred_cnt1
  );
endinterface

// File: rtl/pht.sv
// Pattern History Table: 2-bit saturating counters indexed by {pc_idx, local history}.
// Two registered lookup ports, one training port, with write-to-read forwarding.
module pht #(
  parameter int unsigned BHR_WIDTH      = 3,
  parameter int unsigned PC_INDEX_WIDTH = 3,
  parameter logic [1:0]  CNT_INIT       = 2'b01
) (
  input logic   clock,
  input logic   reset,
  pht_if.slave  pht_bus
);

  localparam int unsigned IW      = PC_INDEX_WIDTH + BHR_WIDTH;
  localparam int unsigned ENTRIES = 1 << IW;

  logic [1:0]    r_table [ENTRIES];

  logic [IW-1:0] w_rd_idx0;
  logic [IW-1:0] w_rd_idx1;
  logic [IW-1:0] w_upd_idx;
  logic [1:0]    w_upd_cur;
  logic [1:0]    w_upd_next;
  logic [1:0]    w_rd_cnt0;
  logic [1:0]    w_rd_cnt1;

  logic          r_pred_valid0;
  logic          r_pred_taken0;
  logic [1:0]    r_pred_cnt0;
  logic          r_pred_valid1;
  logic          r_pred_taken1;
  logic [1:0]    r_pred_cnt1;

  assign w_rd_idx0 = {pht_bus.rd_pc_idx0, pht_bus.rd_hist0};
  assign w_rd_idx1 = {pht_bus.rd_pc_idx1, pht_bus.rd_hist1};
  assign w_upd_idx = {pht_bus.upd_pc_idx, pht_bus.upd_hist};

  // Saturating next value of the counter being trained
  always_comb begin
    w_upd_cur  = r_table[w_upd_idx];
    w_upd_next = w_upd_cur;
    if (pht_bus.upd_taken) begin
      if (w_upd_cur != 2'b11) w_upd_next = w_upd_cur + 2'd1;
    end else begin
      if (w_upd_cur != 2'b00) w_upd_next = w_upd_cur - 2'd1;
    end
  end

  // Read values, forwarding a same-cycle update so lookups never see a stale counter
  always_comb begin
    w_rd_cnt0 = r_table[w_rd_idx0];
    w_rd_cnt1 = r_table[w_rd_idx1];
    if (pht_bus.upd_en && (w_upd_idx == w_rd_idx0)) w_rd_cnt0 = w_upd_next;
    if (pht_bus.upd_en && (w_upd_idx == w_rd_idx1)) w_rd_cnt1 = w_upd_next;
  end

  // Counter storage: reset to CNT_INIT, reset takes priority over training
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CNT_INIT;
      end
    end else if (pht_bus.upd_en) begin
      r_table[w_upd_idx] <= w_upd_next;
    end
  end

  // Prediction registers; an invalid slot reports all zeros
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pred_valid0 <= 1'b0;
      r_pred_taken0 <= 1'b0;
      r_pred_cnt0   <= 2'b00;
      r_pred_valid1 <= 1'b0;
      r_pred_taken1 <= 1'b0;
      r_pred_cnt1   <= 2'b00;
    end else begin
      r_pred_valid0 <= pht_bus.rd_valid0;
      r_pred_taken0 <= pht_bus.rd_valid0 & w_rd_cnt0[1];
      r_pred_cnt0   <= pht_bus.rd_valid0 ? w_rd_cnt0 : 2'b00;
      r_pred_valid1 <= pht_bus.rd_valid1;
      r_pred_taken1 <= pht_bus.rd_valid1 & w_rd_cnt1[1];
      r_pred_cnt1   <= pht_bus.rd_valid1 ? w_rd_cnt1 : 2'b00;
    end
  end

  assign pht_bus.pred_valid0 = r_pred_valid0;
  assign pht_bus.pred_taken0 = r_pred_taken0;
  assign pht_bus.pred_cnt0   = r_pred_cnt0;
  assign pht_bus.pred_valid1 = r_pred_valid1;
  assign pht_bus.pred_taken1 = r_pred_taken1;
  assign pht_bus.pred_cnt1   = r_pred_cnt1;

endmodule
